// File: rtl/down_timer.sv
// Loadable down-counter timer with a valid/ready load handshake.
// It produces a one-cycle terminal-count pulse and can optionally reload itself.
module down_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] EXPIRE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;
  logic             accept;

  assign busy       = (state == RUN);
  assign tc         = (state == EXPIRE);
  assign load_ready = ((state == IDLE) || (state == EXPIRE)) && !clear;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      Q          <= ZERO;
      reload_reg <= ZERO;
    end else if (clear) begin
      state <= IDLE;
      Q     <= ZERO;
    end else if (accept) begin
      Q          <= load_value;
      reload_reg <= load_value;
      state      <= (load_value != ZERO) ? RUN : EXPIRE;
    end else begin
      case (state)
        IDLE: Q <= ZERO;
        RUN: begin
          if (en) begin
            // A count of 0 in RUN is unreachable, but it still exits rather than wrapping.
            if (Q > ONE) begin
              Q <= Q - ONE;
            end else begin
              Q     <= ZERO;
              state <= EXPIRE;
            end
          end
        end
        EXPIRE: begin
          if (AUTO_RELOAD && (reload_reg != ZERO)) begin
            Q     <= reload_reg;
            state <= RUN;
          end else begin
            Q     <= ZERO;
            state <= IDLE;
          end
        end
        default: begin
          Q     <= ZERO;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Random and directed stimulus drives down_timer with and without auto-reload.
// Every cycle, each instance is compared against a behavioural model.
module tb_down_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         load_valid = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] q [2];
  logic         busy [2];
  logic         tc [2];
  logic         ready [2];

  int n_chk = 0;
  int n_pass = 0;

  int mq [2];
  int mrl [2];
  bit mrun [2];
  bit mexp [2];

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
    .load_value(load_value), .load_ready(ready[0]), .en(en),
    .Q(q[0]), .busy(busy[0]), .tc(tc[0]));

  down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid),
    .load_value(load_value), .load_ready(ready[1]), .en(en),
    .Q(q[1]), .busy(busy[1]), .tc(tc[1]));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic mreset();
    for (int a = 0; a < 2; a++) begin
      mq[a] = 0; mrl[a] = 0; mrun[a] = 0; mexp[a] = 0;
    end
  endtask

  // Applies one clock edge of the specified rules to instance a (a == its auto-reload flag).
  task automatic mstep(input int a);
    if (clear) begin
      mrun[a] = 0; mexp[a] = 0; mq[a] = 0;
    end else if (load_valid && !mrun[a]) begin
      mq[a] = int'(load_value); mrl[a] = int'(load_value);
      mrun[a] = (load_value != 0); mexp[a] = (load_value == 0);
    end else if (mrun[a]) begin
      if (en) begin
        mq[a] = mq[a] - 1;
        if (mq[a] == 0) begin mrun[a] = 0; mexp[a] = 1; end
      end
    end else if (mexp[a]) begin
      mexp[a] = 0;
      if (a == 1 && mrl[a] != 0) begin mq[a] = mrl[a]; mrun[a] = 1; end
      else mq[a] = 0;
    end
  endtask

  task automatic check_all();
    for (int a = 0; a < 2; a++) begin
      chk($sformatf("q%0d", a), int'(q[a]), mq[a]);
      chk($sformatf("busy%0d", a), int'(busy[a]), int'(mrun[a]));
      chk($sformatf("tc%0d", a), int'(tc[a]), int'(mexp[a]));
      chk($sformatf("ready%0d", a), int'(ready[a]), int'(!mrun[a] && !clear));
    end
  endtask

  task automatic cycle();
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit lv, input int val, input bit e, input bit c);
    load_valid = lv;
    load_value = W'(val);
    en = e;
    clear = c;
    cycle();
  endtask

  int cnt;

  initial begin
    mreset();
    #12;
    check_all();
    chk("rst_q1", int'(q[1]), 0);
    reset = 1'b0;
    #1;

    // Reset while u0 is counting at Q=5 takes effect without a clock edge.
    drive(1, 5, 1, 0);
    chk("run_q5", int'(q[0]), 5);
    #2 reset = 1'b1;
    #1;
    mreset();
    check_all();
    chk("async_q", int'(q[0]), 0);
    chk("async_ready", int'(ready[0]), 1);
    reset = 1'b0;
    #1;
    @(posedge clk);
    #1;

    // Load 3: u0 is busy for 3 cycles and then returns to IDLE.
    drive(0, 0, 0, 1);
    drive(1, 3, 1, 0);
    cnt = int'(busy[0]);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 0);
      cnt += int'(busy[0]);
    end
    chk("busy_cycles", cnt, 3);

    // Load 2 with auto-reload: one tc every 3 cycles.
    drive(0, 0, 0, 1);
    drive(1, 2, 1, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 0);
      cnt += int'(tc[1]);
    end
    chk("tc_pulses", cnt, 4);

    // Load 4 with en toggling while load_valid stays high.
    drive(0, 0, 0, 1);
    drive(1, 4, 1, 0);
    drive(1, 9, 1, 0);
    drive(1, 9, 0, 0);
    drive(1, 9, 1, 0);
    drive(1, 9, 0, 0);
    chk("toggle_q", int'(q[0]), 2);

    // A load of 0 goes straight to EXPIRE.
    drive(0, 0, 0, 1);
    drive(1, 0, 1, 0);
    chk("zero_tc", int'(tc[1]), 1);
    drive(0, 0, 1, 0);

    // A load of 1 reaches EXPIRE, where a new load of 7 beats the reload.
    drive(0, 0, 0, 1);
    drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 7, 1, 0);
    chk("exp_load", int'(q[1]), 7);

    // clear with load_valid in IDLE does not load.
    drive(0, 0, 0, 1);
    drive(1, 6, 1, 1);
    drive(1, 15, 1, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);

    for (int i = 0; i < 600; i++)
      drive(($urandom % 3) == 0, int'($urandom % 16), ($urandom % 4) != 0,
            ($urandom % 24) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
